// File: rtl/msx_kbd_pkg.sv
// Shared types and constants for the PS/2-to-MSX keyboard matrix responder.
package msx_kbd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBrk,
    StExt,
    StExtBrk,
    StSkip
  } kbd_state_e;

  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  localparam int unsigned MSX_ROWS       = 11;
  localparam logic [2:0]  PAUSE_SKIP_LEN = 3'd7;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } map_res_t;

  function automatic map_res_t key_at(input logic [3:0] row, input logic [2:0] col);
    map_res_t res;
    res.hit = 1'b1;
    res.row = row;
    res.col = col;
    return res;
  endfunction

  // Bytes that never reach the lookup when seen outside a prefix sequence.
  function automatic logic is_idle_special(input logic [7:0] b);
    return (b == PS2_BRK) || (b == PS2_EXT) || (b == PS2_PAUSE) || (b == PS2_BAT_OK) ||
           (b == PS2_ACK) || (b == PS2_ECHO) || (b == PS2_RESEND);
  endfunction

endpackage

// File: rtl/msx_keyboard_if.sv
// Byte input, flush and row/column port bundle of the MSX keyboard responder.
interface msx_keyboard_if;
  logic [7:0] kb_data_i;
  logic       kb_valid_i;
  logic       flush_i;
  logic [3:0] row_i;
  logic [7:0] cols_o;

  modport master (output kb_data_i, output kb_valid_i, output flush_i, output row_i,
                  input cols_o);
  modport slave  (input kb_data_i, input kb_valid_i, input flush_i, input row_i,
                  output cols_o);
endinterface

// File: rtl/msx_kbd_map.sv
// Combinational PS/2 set-2 {ext, code} to MSX matrix position lookup.
// Keypad entries (rows 9-10) exist only when MSX_KBD_NUMPAD_EN is defined.
module msx_kbd_map
  import msx_kbd_pkg::*;
(
  input  logic       i_ext,
  input  logic [7:0] i_code,
  output map_res_t   o_res
);

  always_comb begin
    o_res = '0;
    case ({i_ext, i_code})
      9'h045: o_res = key_at(4'd0, 3'd0);  9'h016: o_res = key_at(4'd0, 3'd1);
      9'h01E: o_res = key_at(4'd0, 3'd2);  9'h026: o_res = key_at(4'd0, 3'd3);
      9'h025: o_res = key_at(4'd0, 3'd4);  9'h02E: o_res = key_at(4'd0, 3'd5);
      9'h036: o_res = key_at(4'd0, 3'd6);  9'h03D: o_res = key_at(4'd0, 3'd7);
      9'h03E: o_res = key_at(4'd1, 3'd0);  9'h046: o_res = key_at(4'd1, 3'd1);
      9'h04E: o_res = key_at(4'd1, 3'd2);  9'h055: o_res = key_at(4'd1, 3'd3);
      9'h05D: o_res = key_at(4'd1, 3'd4);  9'h054: o_res = key_at(4'd1, 3'd5);
      9'h05B: o_res = key_at(4'd1, 3'd6);  9'h04C: o_res = key_at(4'd1, 3'd7);
      9'h052: o_res = key_at(4'd2, 3'd0);  9'h00E: o_res = key_at(4'd2, 3'd1);
      9'h041: o_res = key_at(4'd2, 3'd2);  9'h049: o_res = key_at(4'd2, 3'd3);
      9'h04A: o_res = key_at(4'd2, 3'd4);  9'h01C: o_res = key_at(4'd2, 3'd6);
      9'h032: o_res = key_at(4'd2, 3'd7);
      9'h021: o_res = key_at(4'd3, 3'd0);  9'h023: o_res = key_at(4'd3, 3'd1);
      9'h024: o_res = key_at(4'd3, 3'd2);  9'h02B: o_res = key_at(4'd3, 3'd3);
      9'h034: o_res = key_at(4'd3, 3'd4);  9'h033: o_res = key_at(4'd3, 3'd5);
      9'h043: o_res = key_at(4'd3, 3'd6);  9'h03B: o_res = key_at(4'd3, 3'd7);
      9'h042: o_res = key_at(4'd4, 3'd0);  9'h04B: o_res = key_at(4'd4, 3'd1);
      9'h03A: o_res = key_at(4'd4, 3'd2);  9'h031: o_res = key_at(4'd4, 3'd3);
      9'h044: o_res = key_at(4'd4, 3'd4);  9'h04D: o_res = key_at(4'd4, 3'd5);
      9'h015: o_res = key_at(4'd4, 3'd6);  9'h02D: o_res = key_at(4'd4, 3'd7);
      9'h01B: o_res = key_at(4'd5, 3'd0);  9'h02C: o_res = key_at(4'd5, 3'd1);
      9'h03C: o_res = key_at(4'd5, 3'd2);  9'h02A: o_res = key_at(4'd5, 3'd3);
      9'h01D: o_res = key_at(4'd5, 3'd4);  9'h022: o_res = key_at(4'd5, 3'd5);
      9'h035: o_res = key_at(4'd5, 3'd6);  9'h01A: o_res = key_at(4'd5, 3'd7);
      // Both SHIFTs and both CTRLs fold onto one MSX bit each.
      9'h012: o_res = key_at(4'd6, 3'd0);  9'h059: o_res = key_at(4'd6, 3'd0);
      9'h014: o_res = key_at(4'd6, 3'd1);  9'h114: o_res = key_at(4'd6, 3'd1);
      9'h011: o_res = key_at(4'd6, 3'd2);  9'h058: o_res = key_at(4'd6, 3'd3);
      9'h111: o_res = key_at(4'd6, 3'd4);  9'h005: o_res = key_at(4'd6, 3'd5);
      9'h006: o_res = key_at(4'd6, 3'd6);  9'h004: o_res = key_at(4'd6, 3'd7);
      9'h00C: o_res = key_at(4'd7, 3'd0);  9'h003: o_res = key_at(4'd7, 3'd1);
      9'h076: o_res = key_at(4'd7, 3'd2);  9'h00D: o_res = key_at(4'd7, 3'd3);
      9'h00A: o_res = key_at(4'd7, 3'd4);  9'h066: o_res = key_at(4'd7, 3'd5);
      9'h083: o_res = key_at(4'd7, 3'd6);  9'h05A: o_res = key_at(4'd7, 3'd7);
      9'h15A: o_res = key_at(4'd7, 3'd7);
      9'h029: o_res = key_at(4'd8, 3'd0);  9'h16C: o_res = key_at(4'd8, 3'd1);
      9'h170: o_res = key_at(4'd8, 3'd2);  9'h171: o_res = key_at(4'd8, 3'd3);
      9'h16B: o_res = key_at(4'd8, 3'd4);  9'h175: o_res = key_at(4'd8, 3'd5);
      9'h172: o_res = key_at(4'd8, 3'd6);  9'h174: o_res = key_at(4'd8, 3'd7);
`ifdef MSX_KBD_NUMPAD_EN
      9'h07C: o_res = key_at(4'd9, 3'd0);  9'h079: o_res = key_at(4'd9, 3'd1);
      9'h14A: o_res = key_at(4'd9, 3'd2);  9'h070: o_res = key_at(4'd9, 3'd3);
      9'h069: o_res = key_at(4'd9, 3'd4);  9'h072: o_res = key_at(4'd9, 3'd5);
      9'h07A: o_res = key_at(4'd9, 3'd6);  9'h06B: o_res = key_at(4'd9, 3'd7);
      9'h073: o_res = key_at(4'd10, 3'd0); 9'h074: o_res = key_at(4'd10, 3'd1);
      9'h06C: o_res = key_at(4'd10, 3'd2); 9'h075: o_res = key_at(4'd10, 3'd3);
      9'h07D: o_res = key_at(4'd10, 3'd4); 9'h07B: o_res = key_at(4'd10, 3'd5);
      9'h071: o_res = key_at(4'd10, 3'd7);
`endif
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/msx_keyboard.sv
// PS/2 set-2 to MSX key matrix responder: prefix FSM, matrix flops, registered column read.
// MSX_KBD_NUMPAD_EN adds keypad rows 9-10; otherwise those rows read 8'hFF with no storage.
module msx_keyboard
  import msx_kbd_pkg::*;
(
  input  logic           clk_i,
  input  logic           reset_n_i,
  msx_keyboard_if.slave  kbd
);

`ifdef MSX_KBD_NUMPAD_EN
  localparam int unsigned ImplRows = MSX_ROWS;
`else
  localparam int unsigned ImplRows = MSX_ROWS - 2;
`endif
  localparam logic [3:0] ImplRowsL = 4'(ImplRows);

  kbd_state_e r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_matrix [ImplRows];
  logic [7:0] r_cols;

  logic       w_ext;
  map_res_t   w_map;
  logic       w_wr_en;
  logic       w_wr_val;

  assign w_ext = (r_state == StExt) || (r_state == StExtBrk);

  msx_kbd_map u_map (
    .i_ext  (w_ext),
    .i_code (kbd.kb_data_i),
    .o_res  (w_map)
  );

  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_val = 1'b0;
    unique case (r_state)
      StIdle:   w_wr_en = !is_idle_special(kbd.kb_data_i);
      StBrk:    begin w_wr_en = 1'b1; w_wr_val = 1'b1; end
      StExt:    w_wr_en = (kbd.kb_data_i != PS2_BRK);
      StExtBrk: begin w_wr_en = 1'b1; w_wr_val = 1'b1; end
      default:  w_wr_en = 1'b0;
    endcase
    // Misses and rows without storage leave the matrix untouched.
    w_wr_en = w_wr_en && kbd.kb_valid_i && !kbd.flush_i && w_map.hit &&
              (w_map.row < ImplRowsL);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else if (kbd.flush_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else if (kbd.kb_valid_i) begin
      unique case (r_state)
        StIdle: begin
          if (kbd.kb_data_i == PS2_BRK) begin
            r_state <= StBrk;
          end else if (kbd.kb_data_i == PS2_EXT) begin
            r_state <= StExt;
          end else if (kbd.kb_data_i == PS2_PAUSE) begin
            r_state <= StSkip;
            r_cnt   <= PAUSE_SKIP_LEN;
          end
        end
        StBrk:    r_state <= StIdle;
        StExt:    r_state <= (kbd.kb_data_i == PS2_BRK) ? StExtBrk : StIdle;
        StExtBrk: r_state <= StIdle;
        StSkip: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) r_state <= StIdle;
        end
        default:  r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int r = 0; r < ImplRows; r++) r_matrix[r] <= '1;
    end else if (kbd.flush_i) begin
      for (int r = 0; r < ImplRows; r++) r_matrix[r] <= '1;
    end else if (w_wr_en) begin
      r_matrix[w_map.row][w_map.col] <= w_wr_val;
    end
  end

  // Reads the pre-update matrix, so a same-cycle write shows up one cycle later.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cols <= 8'hFF;
    end else begin
      r_cols <= (kbd.row_i < ImplRowsL) ? r_matrix[kbd.row_i] : 8'hFF;
    end
  end

  assign kbd.cols_o = r_cols;

endmodule
